// File: rtl/debug_bridge_pkg.sv
// Shared opcodes, response codes, FSM states and bus payload type for the
// UART-to-debug-bus command bridge.
package debug_bridge_pkg;

    localparam int unsigned DBG_AW = 8;
    localparam int unsigned DBG_DW = 16;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_D0,
        ST_D1,
        ST_XFER,
        ST_RSP0,
        ST_RSP1
    } state_e;

    typedef struct packed {
        logic [DBG_DW-1:0] di;
        logic [DBG_AW-1:0] a;
    } dbg_req_t;

endpackage

// File: rtl/debug_cmd_bridge.sv
// Parses write/read commands from an RX byte stream, runs one debug-bus
// transaction and returns ACK/NAK or the read data on a TX byte stream.
module debug_cmd_bridge
    import debug_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DBG_AW-1:0] dbg_a,
    output logic [DBG_DW-1:0] dbg_di,
    output logic              dbg_we,
    output logic              dbg_rd,
    input  logic [DBG_DW-1:0] dbg_do,
    input  logic              dbg_ready,
    output logic              busy,
    output logic              rx_overrun
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 op_rd_q, op_rd_d;
    logic                 rsp_two_q, rsp_two_d;
    dbg_req_t             req_q, req_d;
    logic [DBG_DW-1:0]    resp_q, resp_d;
    logic                 we_q, we_d;
    logic                 rd_q, rd_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 busy_q;
    logic                 ovr_q, ovr_d;
    logic                 tc;

    // Terminal count: the 2**TIMEOUT_W-th cycle since the last clear.
    assign tc = (cnt_q == CNT_MAX);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_rd_d    = op_rd_q;
        rsp_two_d  = rsp_two_q;
        req_d      = req_q;
        resp_d     = resp_q;
        we_d       = we_q;
        rd_d       = rd_q;
        tx_valid_d = tx_valid_q;
        ovr_d      = ovr_q;

        if (rx_valid && (state_q inside {ST_XFER, ST_RSP0, ST_RSP1})) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == OP_WR || rx_data == OP_RD)) begin
                    op_rd_d = (rx_data == OP_RD);
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    req_d.a = rx_data;
                    if (op_rd_q) begin
                        rd_d    = 1'b1;
                        state_d = ST_XFER;
                    end else begin
                        state_d = ST_D0;
                    end
                end else if (tc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_D0: begin
                if (rx_valid) begin
                    req_d.di[7:0] = rx_data;
                    state_d       = ST_D1;
                end else if (tc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_D1: begin
                if (rx_valid) begin
                    req_d.di[15:8] = rx_data;
                    we_d           = 1'b1;
                    state_d        = ST_XFER;
                end else if (tc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                // Ready in the terminal-count cycle takes priority over timeout.
                if (dbg_ready) begin
                    we_d       = 1'b0;
                    rd_d       = 1'b0;
                    tx_valid_d = 1'b1;
                    rsp_two_d  = op_rd_q;
                    resp_d     = op_rd_q ? dbg_do : DBG_DW'(RSP_ACK);
                    state_d    = ST_RSP0;
                end else if (tc) begin
                    we_d       = 1'b0;
                    rd_d       = 1'b0;
                    tx_valid_d = 1'b1;
                    rsp_two_d  = 1'b0;
                    resp_d     = DBG_DW'(RSP_NAK);
                    state_d    = ST_RSP0;
                end
            end
            ST_RSP0: begin
                if (tx_ready) begin
                    if (rsp_two_q) begin
                        resp_d  = DBG_DW'(resp_q[15:8]);
                        state_d = ST_RSP1;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_RSP1: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                we_d       = 1'b0;
                rd_d       = 1'b0;
                tx_valid_d = 1'b0;
            end
        endcase

        // Shared timeout counter: cleared on any state change or received byte.
        if (state_d != state_q || rx_valid) begin
            cnt_d = '0;
        end else if (!tc) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_rd_q    <= 1'b0;
            rsp_two_q  <= 1'b0;
            req_q      <= '0;
            resp_q     <= '0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_rd_q    <= op_rd_d;
            rsp_two_q  <= rsp_two_d;
            req_q      <= req_d;
            resp_q     <= resp_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= (state_d != ST_IDLE);
            ovr_q      <= ovr_d;
        end
    end

    // The response byte on the wire is always the low byte of resp_q.
    assign tx_data    = resp_q[7:0];
    assign tx_valid   = tx_valid_q;
    assign dbg_a      = req_q.a;
    assign dbg_di     = req_q.di;
    assign dbg_we     = we_q;
    assign dbg_rd     = rd_q;
    assign busy       = busy_q;
    assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_debug_cmd_bridge.sv
// Self-checking bench for debug_cmd_bridge: vector table, directed corner
// sequences and randomized commands against a transaction-level model.
module tb_debug_cmd_bridge;
    import debug_bridge_pkg::*;

    localparam int unsigned TW     = 4;
    localparam int          TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  dbg_a;
    logic [15:0] dbg_di;
    logic        dbg_we;
    logic        dbg_rd;
    logic [15:0] dbg_do = 16'h0000;
    logic        dbg_ready = 1'b0;
    logic        busy;
    logic        rx_overrun;

    debug_cmd_bridge #(.TIMEOUT_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dbg_a      (dbg_a),
        .dbg_di     (dbg_di),
        .dbg_we     (dbg_we),
        .dbg_rd     (dbg_rd),
        .dbg_do     (dbg_do),
        .dbg_ready  (dbg_ready),
        .busy       (busy),
        .rx_overrun (rx_overrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Bus responder: asserts ready in strobe cycle ready_delay+1 (-1 = never).
    typedef struct packed {
        logic        we;
        logic [7:0]  a;
        logic [15:0] di;
    } bus_t;

    bus_t        bus_log[$];
    int          ready_delay = 0;
    logic [15:0] rdata = 16'h0000;
    logic        force_ready = 1'b0;
    int          scyc = 0;
    int          last_len = 0;

    always @(posedge clk) begin
        #2;
        dbg_do = 16'($urandom);
        if (dbg_we || dbg_rd) begin
            if (scyc == ready_delay) begin
                dbg_ready = 1'b1;
                dbg_do    = rdata;
                bus_log.push_back('{dbg_we, dbg_a, dbg_di});
            end else begin
                dbg_ready = force_ready;
            end
            scyc++;
        end else begin
            if (scyc != 0) last_len = scyc;
            scyc      = 0;
            dbg_ready = force_ready;
        end
    end

    // TX sink: 0 = always ready, 1 = never, 2 = random; also checks hold stability.
    int         tx_mode = 0;
    logic [7:0] tx_log[$];
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always @(posedge clk) begin
        #2;
        if (hold_prev) begin
            chk("tx_hold_valid", 64'(tx_valid), 64'(1));
            chk("tx_hold_data", 64'(tx_data), 64'(hold_data));
        end
        case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'b0;
            default: tx_ready = ($urandom_range(0, 2) != 0);
        endcase
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        hold_prev = tx_valid && !tx_ready && rst_n;
        hold_data = tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, 64'(busy), 64'(0));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({tx_data, tx_valid, dbg_a, dbg_di, dbg_we, dbg_rd, busy, rx_overrun});
    endfunction

    typedef struct {
        logic [3:0][7:0] b;
        int              nb;
        int              delay;
        logic [15:0]     rdata;
        logic [1:0][7:0] exp_tx;
        int              ntx;
        int              exp_len;
        int              exp_nbus;
        logic            exp_we;
        logic [7:0]      exp_a;
        logic [15:0]     exp_di;
    } vec_t;

    localparam int NV = 7;
    vec_t vec [NV];

    initial begin
        vec[0] = '{{8'h12, 8'h34, 8'h11, 8'h57}, 4,  2, 16'h0000, {8'h00, 8'h06}, 1,  3, 1, 1'b1, 8'h11, 16'h1234};
        vec[1] = '{{8'h00, 8'h00, 8'h20, 8'h52}, 2,  0, 16'hBEEF, {8'hBE, 8'hEF}, 2,  1, 1, 1'b0, 8'h20, 16'h1234};
        vec[2] = '{{8'h00, 8'h00, 8'h20, 8'h52}, 2, -1, 16'h0000, {8'h00, 8'h15}, 1, 16, 0, 1'b0, 8'h00, 16'h0000};
        vec[3] = '{{8'h00, 8'hFF, 8'hA5, 8'h57}, 4, 15, 16'h0000, {8'h00, 8'h06}, 1, 16, 1, 1'b1, 8'hA5, 16'h00FF};
        vec[4] = '{{8'h56, 8'h78, 8'h3C, 8'h57}, 4, -1, 16'h0000, {8'h00, 8'h15}, 1, 16, 0, 1'b0, 8'h00, 16'h0000};
        vec[5] = '{{8'h00, 8'h00, 8'h7F, 8'h52}, 2,  5, 16'h0001, {8'h00, 8'h01}, 2,  6, 1, 1'b0, 8'h7F, 16'h5678};
        vec[6] = '{{8'h00, 8'h00, 8'h00, 8'h52}, 2, 14, 16'h8000, {8'h80, 8'h00}, 2, 15, 1, 1'b0, 8'h00, 16'h5678};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_outs", all_outs(), 64'(0));
        rst_n = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < NV; i++) begin
            tx_log.delete();
            bus_log.delete();
            last_len    = 0;
            ready_delay = vec[i].delay;
            rdata       = vec[i].rdata;
            for (int k = 0; k < vec[i].nb; k++) send(vec[i].b[k]);
            wait_idle($sformatf("v%0d", i));
            tick();
            chk($sformatf("v%0d_ntx", i), 64'(tx_log.size()), 64'(vec[i].ntx));
            if (tx_log.size() == vec[i].ntx) begin
                for (int k = 0; k < vec[i].ntx; k++)
                    chk($sformatf("v%0d_tx%0d", i, k), 64'(tx_log[k]), 64'(vec[i].exp_tx[k]));
            end
            chk($sformatf("v%0d_strobe_len", i), 64'(last_len), 64'(vec[i].exp_len));
            chk($sformatf("v%0d_nbus", i), 64'(bus_log.size()), 64'(vec[i].exp_nbus));
            if (bus_log.size() == 1 && vec[i].exp_nbus == 1) begin
                chk($sformatf("v%0d_we", i), 64'(bus_log[0].we), 64'(vec[i].exp_we));
                chk($sformatf("v%0d_a", i), 64'(bus_log[0].a), 64'(vec[i].exp_a));
                chk($sformatf("v%0d_di", i), 64'(bus_log[0].di), 64'(vec[i].exp_di));
            end
        end

        // Latency: strobe one cycle after last byte, tx_valid one cycle after ready
        tx_log.delete();
        ready_delay = 1;
        send(8'h57);
        send(8'h11);
        send(8'h34);
        send(8'h12);
        chk("lat_we_rise", 64'({dbg_we, tx_valid}), 64'(2'b10));
        tick();
        chk("lat_we_hold", 64'({dbg_we, tx_valid}), 64'(2'b10));
        tick();
        chk("lat_tx_rise", 64'({dbg_we, tx_valid, tx_data}), 64'({2'b01, 8'h06}));
        wait_idle("lat");

        // Non-command byte in IDLE is ignored without overrun
        send(8'hAA);
        tick();
        chk("ignore_byte", 64'({busy, rx_overrun}), 64'(0));

        // Resync after inter-byte silence
        last_len = 0;
        send(8'h57);
        send(8'h11);
        for (int k = 0; k < TO_CYC - 1; k++) tick();
        chk("resync_still_busy", 64'(busy), 64'(1));
        tick();
        chk("resync_idle", 64'({busy, dbg_we, dbg_rd}), 64'(0));
        chk("resync_no_strobe", 64'(last_len), 64'(0));
        tx_log.delete();
        bus_log.delete();
        ready_delay = 0;
        rdata       = 16'h1357;
        send(8'h52);
        send(8'h10);
        wait_idle("resync_rd");
        chk("resync_rd_ntx", 64'(tx_log.size()), 64'(2));
        if (tx_log.size() == 2) chk("resync_rd_data", 64'({tx_log[1], tx_log[0]}), 64'(16'h1357));
        if (bus_log.size() == 1) chk("resync_rd_a", 64'(bus_log[0].a), 64'(8'h10));

        // Backpressure hold plus overrun in RSP0
        tx_log.delete();
        tx_mode     = 1;
        ready_delay = 0;
        rdata       = 16'hBEEF;
        send(8'h52);
        send(8'h20);
        for (int k = 0; k < 10 && !tx_valid; k++) tick();
        chk("bp_tx_valid", 64'({tx_valid, tx_data}), 64'({1'b1, 8'hEF}));
        send(8'h57);
        chk("bp_overrun", 64'(rx_overrun), 64'(1));
        for (int k = 0; k < 4; k++) tick();
        chk("bp_held", 64'({tx_valid, tx_data}), 64'({1'b1, 8'hEF}));
        tx_mode = 0;
        wait_idle("bp");
        tick();
        tick();
        chk("bp_ntx", 64'(tx_log.size()), 64'(2));
        if (tx_log.size() == 2) chk("bp_data", 64'({tx_log[1], tx_log[0]}), 64'(16'hBEEF));
        chk("bp_no_new_cmd", 64'({busy, rx_overrun}), 64'(2'b01));

        // Synchronous reset in XFER
        tx_log.delete();
        ready_delay = -1;
        send(8'h52);
        send(8'h20);
        tick();
        chk("rst_xfer_rd", 64'(dbg_rd), 64'(1));
        rst_n = 1'b0;
        tick();
        chk("rst_xfer_outs", all_outs(), 64'(0));
        rst_n       = 1'b1;
        force_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_ready_ignored", 64'({tx_valid, busy, dbg_rd, dbg_we}), 64'(0));
        chk("rst_no_tx", 64'(tx_log.size()), 64'(0));
        force_ready = 1'b0;
        tick();

        // Randomized commands against a transaction-level model
        begin
            logic [15:0] di_model = 16'h0000;
            tx_mode = 2;
            for (int it = 0; it < 40; it++) begin
                logic        is_rd;
                logic [7:0]  a;
                logic [15:0] d;
                int          dly;
                logic [7:0]  exp_tx[$];
                bit          ok;
                int          njunk;

                is_rd = 1'($urandom);
                a     = 8'($urandom);
                d     = 16'($urandom);
                dly   = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20));
                rdata = 16'($urandom);
                ready_delay = dly;
                tx_log.delete();
                bus_log.delete();
                last_len = 0;

                njunk = $urandom_range(0, 2);
                for (int j = 0; j < njunk; j++) begin
                    logic [7:0] jb;
                    jb = 8'($urandom);
                    if (jb == OP_WR || jb == OP_RD) jb = 8'h00;
                    send(jb);
                end
                send(is_rd ? OP_RD : OP_WR);
                repeat ($urandom_range(0, 3)) tick();
                send(a);
                if (!is_rd) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send(d[7:0]);
                    repeat ($urandom_range(0, 3)) tick();
                    send(d[15:8]);
                    di_model = d;
                end

                ok = (dly >= 0) && (dly < TO_CYC);
                if (!ok)       exp_tx = '{RSP_NAK};
                else if (is_rd) exp_tx = '{rdata[7:0], rdata[15:8]};
                else           exp_tx = '{RSP_ACK};

                wait_idle($sformatf("r%0d", it));
                tick();
                chk($sformatf("r%0d_ntx", it), 64'(tx_log.size()), 64'(exp_tx.size()));
                if (tx_log.size() == exp_tx.size()) begin
                    for (int k = 0; k < exp_tx.size(); k++)
                        chk($sformatf("r%0d_tx%0d", it, k), 64'(tx_log[k]), 64'(exp_tx[k]));
                end
                chk($sformatf("r%0d_len", it), 64'(last_len), 64'(ok ? dly + 1 : TO_CYC));
                chk($sformatf("r%0d_nbus", it), 64'(bus_log.size()), 64'(ok ? 1 : 0));
                if (ok && bus_log.size() == 1) begin
                    chk($sformatf("r%0d_bus", it), 64'(bus_log[0]), 64'(bus_t'({!is_rd, a, di_model})));
                end
            end
            tx_mode = 0;
            tick();
            chk("rand_no_overrun", 64'(rx_overrun), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
